// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: FSM encoding,
// round-robin pointer encoding and default bank geometry.
package reg_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    CLEAR = 2'b10
  } state_e;

  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } ptr_e;

  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_DATA_W   = 32;

endpackage

// File: rtl/reg_write_arbiter_load.sv
// Register-index to one-hot load-enable decoder; index 0 never produces a
// load because register 0 is the hard-wired zero register.
module reg_load_decoder #(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                i_en,
  input  logic [IDX_W-1:0]    i_idx,
  output logic [NUM_REGS-1:0] o_load
);

  always_comb begin
    o_load = '0;
    if (i_en && (i_idx != '0)) begin
      o_load[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin write arbiter for a D_FF register bank.
// Define REG_WRITE_ARBITER_CLEAR_EN to add the bulk-clear sequencer (clr_req/clr_done).
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int DATA_W   = DEFAULT_DATA_W,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic                C,
  input  logic                nR,
  input  logic                req_a,
  input  logic                req_b,
  input  logic [IDX_W-1:0]    addr_a,
  input  logic [IDX_W-1:0]    addr_b,
  input  logic [DATA_W-1:0]   wdata_a,
  input  logic [DATA_W-1:0]   wdata_b,
`ifdef REG_WRITE_ARBITER_CLEAR_EN
  input  logic                clr_req,
  output logic                clr_done,
`endif
  output logic                gnt_a,
  output logic                gnt_b,
  output logic [NUM_REGS-1:0] reg_load,
  output logic [DATA_W-1:0]   reg_d,
  output logic                busy
);

  state_e                r_state;
  state_e                w_nextState;
  ptr_e                  r_ptr;
  ptr_e                  w_ptrNext;
  logic                  r_gntA;
  logic                  r_gntB;
  logic                  w_gntANext;
  logic                  w_gntBNext;
  logic                  r_busy;
  logic [NUM_REGS-1:0]   r_regLoad;
  logic [NUM_REGS-1:0]   w_loadNext;
  logic [DATA_W-1:0]     r_regD;
  logic [DATA_W-1:0]     w_regDNext;
  logic                  w_loadEn;
  logic [IDX_W-1:0]      w_loadIdx;
  logic                  w_anyReq;
  logic                  w_winB;

`ifdef REG_WRITE_ARBITER_CLEAR_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [IDX_W-1:0]      r_clrIdx;
  logic [IDX_W-1:0]      w_clrIdxNext;
  logic                  r_clrDone;
  logic                  w_clrDoneNext;
`endif

  assign w_anyReq = req_a | req_b;
  // The pointer's favourite wins when it asks; otherwise the other side does.
  assign w_winB   = (r_ptr == PTR_B) ? req_b : !req_a;

  reg_load_decoder #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_loadDecoder (
    .i_en   (w_loadEn),
    .i_idx  (w_loadIdx),
    .o_load (w_loadNext)
  );

  always_comb begin
    w_nextState = r_state;
    w_ptrNext   = r_ptr;
    w_gntANext  = 1'b0;
    w_gntBNext  = 1'b0;
    w_loadEn    = 1'b0;
    w_loadIdx   = '0;
    w_regDNext  = r_regD;
`ifdef REG_WRITE_ARBITER_CLEAR_EN
    w_clrIdxNext  = r_clrIdx;
    w_clrDoneNext = 1'b0;
`endif
    case (r_state)
      IDLE: begin
`ifdef REG_WRITE_ARBITER_CLEAR_EN
        if (clr_req) begin
          w_nextState  = CLEAR;
          w_loadEn     = 1'b1;
          w_loadIdx    = IDX_W'(1);
          w_regDNext   = '0;
          w_clrIdxNext = IDX_W'(1);
        end else
`endif
        if (w_anyReq) begin
          w_nextState = WRITE;
          w_gntANext  = !w_winB;
          w_gntBNext  = w_winB;
          w_loadEn    = 1'b1;
          w_loadIdx   = w_winB ? addr_b : addr_a;
          w_regDNext  = w_winB ? wdata_b : wdata_a;
          w_ptrNext   = w_winB ? PTR_A : PTR_B;
        end
      end
      WRITE: begin
        w_nextState = IDLE;
      end
`ifdef REG_WRITE_ARBITER_CLEAR_EN
      CLEAR: begin
        if (r_clrIdx == LAST_IDX) begin
          w_nextState   = IDLE;
          w_clrIdxNext  = '0;
          w_clrDoneNext = 1'b1;
        end else begin
          w_clrIdxNext = r_clrIdx + IDX_W'(1);
          w_loadEn     = 1'b1;
          w_loadIdx    = r_clrIdx + IDX_W'(1);
          w_regDNext   = '0;
        end
      end
`endif
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Outputs are registered so the bank sees clean, glitch-free load enables.
  always_ff @(posedge C) begin
    if (!nR) begin
      r_state   <= IDLE;
      r_ptr     <= PTR_A;
      r_gntA    <= 1'b0;
      r_gntB    <= 1'b0;
      r_regLoad <= '0;
      r_regD    <= '0;
      r_busy    <= 1'b0;
`ifdef REG_WRITE_ARBITER_CLEAR_EN
      r_clrIdx  <= '0;
      r_clrDone <= 1'b0;
`endif
    end else begin
      r_state   <= w_nextState;
      r_ptr     <= w_ptrNext;
      r_gntA    <= w_gntANext;
      r_gntB    <= w_gntBNext;
      r_regLoad <= w_loadNext;
      r_regD    <= w_regDNext;
      r_busy    <= (w_nextState != IDLE);
`ifdef REG_WRITE_ARBITER_CLEAR_EN
      r_clrIdx  <= w_clrIdxNext;
      r_clrDone <= w_clrDoneNext;
`endif
    end
  end

  assign gnt_a    = r_gntA;
  assign gnt_b    = r_gntB;
  assign reg_load = r_regLoad;
  assign reg_d    = r_regD;
  assign busy     = r_busy;
`ifdef REG_WRITE_ARBITER_CLEAR_EN
  assign clr_done = r_clrDone;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a transaction-level model predicts
// every active output cycle; a negedge monitor compares the DUT against it.
module tb_reg_write_arbiter;

  localparam int NUM_REGS = 32;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef struct {
    int                  cyc;
    bit                  ga;
    bit                  gb;
    bit                  cd;
    bit                  busy;
    logic [NUM_REGS-1:0] load;
    logic [DATA_W-1:0]   d;
  } exp_t;

  logic                C = 1'b0;
  logic                nR;
  logic                req_a;
  logic                req_b;
  logic [IDX_W-1:0]    addr_a;
  logic [IDX_W-1:0]    addr_b;
  logic [DATA_W-1:0]   wdata_a;
  logic [DATA_W-1:0]   wdata_b;
  logic                gnt_a;
  logic                gnt_b;
  logic [NUM_REGS-1:0] reg_load;
  logic [DATA_W-1:0]   reg_d;
  logic                busy;
  logic                clrDoneSig;

  exp_t              q[$];
  int                testsRun    = 0;
  int                testsFailed = 0;
  int                cyc         = 0;
  bit                rstSampled  = 1'b0;
  int                nextFree    = 0;
  bit                ptrB        = 1'b0;
  int                expGrants   = 0;
  int                obsGrants   = 0;
  logic [DATA_W-1:0] lastD       = '0;

`ifdef REG_WRITE_ARBITER_CLEAR_EN
  logic clr_req;
  logic clr_done;
  assign clrDoneSig = clr_done;
`else
  assign clrDoneSig = 1'b0;
`endif

  reg_write_arbiter #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) dut (
    .C        (C),
    .nR       (nR),
    .req_a    (req_a),
    .req_b    (req_b),
    .addr_a   (addr_a),
    .addr_b   (addr_b),
    .wdata_a  (wdata_a),
    .wdata_b  (wdata_b),
`ifdef REG_WRITE_ARBITER_CLEAR_EN
    .clr_req  (clr_req),
    .clr_done (clr_done),
`endif
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .reg_load (reg_load),
    .reg_d    (reg_d),
    .busy     (busy)
  );

  always #5 C = ~C;

  function automatic logic [127:0] packOut(input bit ga, input bit gb, input bit cd,
                                           input bit bz, input logic [NUM_REGS-1:0] ld,
                                           input logic [DATA_W-1:0] d);
    return {60'd0, ga, gb, cd, bz, ld, d};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s cycle %0d: actual %h required %h", name, cyc, act, req);
    end
  endtask

  // Reference model: a write occupies the edge it is accepted plus one more,
  // a clear occupies NUM_REGS-1 load cycles plus the done cycle.
  initial begin
    exp_t             e;
    bit               started;
    bit               winB;
    logic [IDX_W-1:0] a;
    forever begin
      @(posedge C);
      cyc++;
      rstSampled = !nR;
      if (!nR) begin
        while (q.size() > 0 && q[$].cyc >= cyc) void'(q.pop_back());
        nextFree = cyc + 1;
        ptrB     = 1'b0;
      end else if (cyc >= nextFree) begin
        started = 1'b0;
`ifdef REG_WRITE_ARBITER_CLEAR_EN
        if (clr_req) begin
          for (int i = 1; i < NUM_REGS; i++) begin
            e.cyc = cyc + i - 1; e.ga = 0; e.gb = 0; e.cd = 0; e.busy = 1;
            e.load = '0; e.load[i] = 1'b1; e.d = '0;
            q.push_back(e);
          end
          e.cyc = cyc + NUM_REGS - 1; e.ga = 0; e.gb = 0; e.cd = 1; e.busy = 0;
          e.load = '0; e.d = '0;
          q.push_back(e);
          nextFree = cyc + NUM_REGS;
          started  = 1'b1;
        end
`endif
        if (!started && (req_a || req_b)) begin
          if (ptrB) winB = req_b ? 1'b1 : 1'b0;
          else      winB = req_a ? 1'b0 : 1'b1;
          a      = winB ? addr_b : addr_a;
          e.cyc  = cyc; e.ga = !winB; e.gb = winB; e.cd = 0; e.busy = 1;
          e.load = '0;
          if (a != 0) e.load[a] = 1'b1;
          e.d    = winB ? wdata_b : wdata_a;
          q.push_back(e);
          ptrB      = !winB;
          nextFree  = cyc + 2;
          expGrants++;
        end
      end
    end
  end

  // Monitor: pop the prediction for this cycle, otherwise expect quiet outputs.
  initial begin
    exp_t           e;
    logic [127:0]   act;
    forever begin
      @(negedge C);
      act = packOut(gnt_a, gnt_b, clrDoneSig, busy, reg_load, reg_d);
      if (gnt_a || gnt_b) obsGrants++;
      if (rstSampled) begin
        lastD = '0;
        checkOutput("reset", act, packOut(0, 0, 0, 0, '0, '0));
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        checkOutput(e.cd ? "clrDone" : ((e.ga || e.gb) ? "grant" : "clearLoad"),
                    act, packOut(e.ga, e.gb, e.cd, e.busy, e.load, e.d));
        lastD = e.d;
      end else begin
        checkOutput("idle", act, packOut(0, 0, 0, 0, '0, lastD));
      end
    end
  end

  // Requester agents: hold until granted, drop in the grant cycle, re-request randomly.
  task automatic applyStimulus(input int cycles, input int pa, input int pb,
                               input int pc, input int prst);
    for (int n = 0; n < cycles; n++) begin
      @(posedge C);
      #2;
      nR = ($urandom_range(0, 999) < prst) ? 1'b0 : 1'b1;
      if (gnt_a) req_a = 1'b0;
      else if (!req_a && ($urandom_range(0, 99) < pa)) begin
        req_a = 1'b1; addr_a = IDX_W'($urandom_range(0, NUM_REGS - 1)); wdata_a = $urandom();
      end
      if (gnt_b) req_b = 1'b0;
      else if (!req_b && ($urandom_range(0, 99) < pb)) begin
        req_b = 1'b1; addr_b = IDX_W'($urandom_range(0, NUM_REGS - 1)); wdata_b = $urandom();
      end
`ifdef REG_WRITE_ARBITER_CLEAR_EN
      if (clr_done) clr_req = 1'b0;
      else if (!clr_req && ($urandom_range(0, 99) < pc)) clr_req = 1'b1;
`else
      if (pc < 0) $display("[TB] note: clear probability ignored");
`endif
    end
  endtask

  initial begin
    nR = 1'b0; req_a = 1'b1; addr_a = IDX_W'(5); wdata_a = 32'hDEADBEEF;
    req_b = 1'b0; addr_b = '0; wdata_b = '0;
`ifdef REG_WRITE_ARBITER_CLEAR_EN
    clr_req = 1'b0;
`endif
    repeat (2) @(posedge C);
    #2 nR = 1'b1;
    applyStimulus(4, 0, 0, 0, 0);

    @(posedge C); #2;
    nR = 1'b0;
    req_a = 1'b1; addr_a = IDX_W'(7); wdata_a = 32'hA5A5_0001;
    req_b = 1'b1; addr_b = IDX_W'(9); wdata_b = 32'h5A5A_0002;
    applyStimulus(16, 100, 100, 0, 0);
    applyStimulus(4, 0, 0, 0, 0);

    @(posedge C); #2;
    req_b = 1'b1; addr_b = '0; wdata_b = 32'h1234_5678;
    applyStimulus(4, 0, 0, 0, 0);
    @(posedge C); #2;
    req_a = 1'b1; addr_a = IDX_W'(NUM_REGS - 1); wdata_a = 32'hFFFF_0000;
    applyStimulus(4, 0, 0, 0, 0);

`ifdef REG_WRITE_ARBITER_CLEAR_EN
    @(posedge C); #2;
    clr_req = 1'b1; req_a = 1'b1; addr_a = IDX_W'(3); wdata_a = 32'hC0FF_EE00;
    applyStimulus(NUM_REGS + 4, 0, 0, 0, 0);
    @(posedge C); #2;
    clr_req = 1'b1;
    applyStimulus(9, 0, 0, 0, 0);
    @(posedge C); #2;
    nR = 1'b0; clr_req = 1'b0;
    applyStimulus(4, 0, 0, 0, 0);
`endif

    applyStimulus(600, 40, 40, 2, 8);
    applyStimulus(2 * NUM_REGS + 8, 0, 0, 0, 0);

    @(negedge C); #1;
    checkOutput("queueDrained", 128'(q.size()), 128'd0);
    checkOutput("grantCount", 128'(obsGrants), 128'(expGrants));
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
